// File: rtl/mips_pkg.sv
// Shared types for the MIPS instruction-fetch front end.
// Latency: n/a (types, constants and a PC-alignment helper only).
// Backpressure: n/a.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [31:0]        pc;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // Instruction addresses are word aligned; low bits of any target are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_fetch_fifo.sv
// Prefetch FIFO holding fetch_entry_t words {instr, pc}; head is read straight from storage.
// Latency: a push is visible at o_head_dat the cycle after; flush empties it on the next edge.
// Backpressure: push when full is dropped unless a pop happens in the same cycle; pop when empty is ignored.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_flush         discard all entries (wins over push/pop)
//   i_push/i_push_dat  write one entry
//   i_pop           retire the head entry
//   o_head_dat      head entry (undefined content when o_empty)
//   o_count         number of valid entries
//   o_empty         no valid entries
module mips_fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [ENTRY_W-1:0] i_push_dat,
  input  logic               i_pop,
  output logic [ENTRY_W-1:0] o_head_dat,
  output logic [CW-1:0]      o_count,
  output logic               o_empty
);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;

  logic w_full;
  logic w_pop;
  logic w_push;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && !o_empty;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign w_push  = i_push && (!w_full || w_pop);

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed once counted valid.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: sequential PC generation, in-order imem requests, prefetch FIFO, redirect flush.
// Latency: imem response in cycle t appears on id_* in t+1; first instruction 3 cycles after reset release.
// Backpressure: requests are credit limited to FIFO_DEPTH (buffered + outstanding); id_ready stalls the head.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   imem_req_valid/ready/addr   fetch request channel (addr held while stalled)
//   imem_rsp_valid/data         in-order read data, one per accepted request
//   redirect_valid/pc           taken branch/jump pulse and its target
//   id_valid/ready              decode handshake on the FIFO head
//   id_instr/id_pc/id_pc_plus4  head instruction (NOP when invalid), its address and address+4
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  // Stale responses can pile up across back-to-back redirects, so this
  // counter is wider than the live-credit counter.
  localparam int DW = 8;

  fetch_state_e  r_state;
  fetch_state_e  w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] w_outstanding_nxt;
  logic [DW-1:0] r_drop_cnt;
  logic [DW-1:0] w_drop_cnt_nxt;

  logic          w_req_accept;
  logic          w_rsp_drop;
  logic          w_rsp_live;
  logic          w_rsp_orphan;
  logic          w_push;
  logic          w_pop;
  logic [CW:0]   w_credit_used;

  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head_entry;
  logic [CW-1:0] w_fifo_count;
  logic          w_fifo_empty;

  // ------------------------------------------------------------------
  // Request side
  // ------------------------------------------------------------------
  assign w_credit_used  = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  // Valid is dropped during a redirect so a stalled request to the old
  // path is withdrawn rather than accepted.
  assign imem_req_valid = (r_state != S_BOOT)
                       && (w_credit_used < (CW+1)'(FIFO_DEPTH))
                       && !redirect_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_accept   = imem_req_valid && imem_req_ready;

  // ------------------------------------------------------------------
  // Response side: stale responses (old path) are consumed first.
  // ------------------------------------------------------------------
  assign w_rsp_drop   = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_rsp_live   = imem_rsp_valid && (r_drop_cnt == '0) && (r_outstanding != '0);
  assign w_rsp_orphan = imem_rsp_valid && (r_drop_cnt == '0) && (r_outstanding == '0);

  assign w_push = w_rsp_live && !redirect_valid;
  assign w_pop  = id_valid && id_ready && !redirect_valid;

  assign w_push_entry.instr = imem_rsp_data;
  assign w_push_entry.pc    = r_rsp_pc;

  // ------------------------------------------------------------------
  // FSM and credit counters
  // ------------------------------------------------------------------
  always_comb begin
    w_state_nxt       = r_state;
    w_outstanding_nxt = r_outstanding;
    w_drop_cnt_nxt    = r_drop_cnt;
    if (redirect_valid) begin
      // Everything in flight becomes stale. A response landing this same
      // cycle belongs to the old path and is consumed here.
      w_outstanding_nxt = '0;
      w_drop_cnt_nxt    = r_drop_cnt + DW'(r_outstanding) + DW'(w_req_accept)
                        - DW'(w_rsp_drop || w_rsp_live);
      w_state_nxt       = (w_drop_cnt_nxt != '0) ? S_DRAIN : S_RUN;
    end else begin
      w_outstanding_nxt = r_outstanding + CW'(w_req_accept) - CW'(w_rsp_live);
      w_drop_cnt_nxt    = r_drop_cnt - DW'(w_rsp_drop);
      case (r_state)
        S_BOOT:  w_state_nxt = S_RUN;
        S_RUN:   w_state_nxt = S_RUN;
        S_DRAIN: w_state_nxt = (w_drop_cnt_nxt == '0) ? S_RUN : S_DRAIN;
        default: w_state_nxt = S_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_BOOT;
      r_fetch_pc    <= align_pc(RESET_PC);
      r_rsp_pc      <= align_pc(RESET_PC);
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop_cnt    <= w_drop_cnt_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= align_pc(redirect_pc);
        r_rsp_pc   <= align_pc(redirect_pc);
      end else begin
        if (w_req_accept) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)       r_rsp_pc   <= r_rsp_pc + 32'd4;
      end
    end
  end

  // ------------------------------------------------------------------
  // Prefetch buffer and decode outputs
  // ------------------------------------------------------------------
  mips_fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (redirect_valid),
    .i_push    (w_push),
    .i_push_dat(w_push_entry),
    .i_pop     (w_pop),
    .o_head_dat(w_head_entry),
    .o_count   (w_fifo_count),
    .o_empty   (w_fifo_empty)
  );

  assign id_valid    = !w_fifo_empty;
  assign id_instr    = id_valid ? w_head_entry.instr : NOP_INSTR;
  assign id_pc       = id_valid ? w_head_entry.pc : 32'h0;
  assign id_pc_plus4 = id_pc + 32'd4;

  // A response with nothing outstanding breaks the memory protocol; it is
  // ignored by the datapath above.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst) !w_rsp_orphan);

endmodule
